// File: rtl/apb_master_fsm.sv
// APB master that drains packed {write, addr, wdata} requests from a FIFO and
// returns one response per transfer through a valid/ready hold register.
module apb_master_fsm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 16
) (
    input  logic                     pclk,
    input  logic                     prst,
    input  logic [ADDR_W+DATA_W:0]   fifo_rdata,
    input  logic                     fifo_rempty,
    output logic                     fifo_rinc,
    output logic [ADDR_W-1:0]        paddr,
    output logic                     pwrite,
    output logic [DATA_W-1:0]        pwdata,
    output logic                     psel,
    output logic                     penable,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, SETUP, ACCESS} state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            to_hit;

    // No pops while reset is held, so an entry is never lost to a reset edge.
    assign fifo_rinc = (state == IDLE) & ~fifo_rempty & ~rsp_valid & ~prst;
    assign to_hit    = TO_EN & (wait_cnt == TO_LAST) & ~pready;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= IDLE;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fifo_rinc)
                        state <= LOAD;
                end
                LOAD: begin
                    pwrite <= fifo_rdata[ADDR_W+DATA_W];
                    paddr  <= fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
                    pwdata <= fifo_rdata[DATA_W-1:0];
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // Ready on the timeout cycle counts as a normal completion.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= pwrite;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (to_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= pwrite;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: reset, zero-wait write, wait-state read,
// timeout, response backpressure and reset during ACCESS.
module tb_apb_master_fsm;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int PKT_W  = 1 + ADDR_W + DATA_W;

    logic              pclk = 1'b0;
    logic              prst = 1'b1;
    logic [PKT_W-1:0]  fifo_rdata = '0;
    logic              fifo_rempty = 1'b1;
    logic              fifo_rinc;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b1;
    logic              pslverr = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    int total = 0;
    int bad   = 0;

    logic [PKT_W-1:0] fq[$];

    apb_master_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4),
        .TO_W   (16)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 pclk = ~pclk;

    // FIFO model: data appears one pclk after the pop strobe.
    always @(posedge pclk) begin
        if (fifo_rinc && fq.size() > 0) begin
            fifo_rdata  <= fq.pop_front();
            fifo_rempty <= (fq.size() == 0);
        end
    end

    task automatic push(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        fq.push_back({wr, a, d});
        fifo_rempty = 1'b0;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        // Reset held with a non-empty FIFO
        push(1'b1, 32'h0000_1004, 8'hA5);
        tick(); tick();
        check("rst_rinc",    fifo_rinc, 0);
        check("rst_psel",    psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rvalid",  rsp_valid, 0);
        check("rst_paddr",   paddr, 0);
        check("rst_timeout", rsp_timeout, 0);

        // Zero-wait write: pop in first IDLE cycle
        prst = 1'b0; #1;
        check("wr_pop", fifo_rinc, 1);
        tick();
        check("wr_load_psel", psel, 0);
        check("wr_load_rinc", fifo_rinc, 0);
        tick();
        check("wr_setup_psel",    psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr",   paddr, 64'h1004);
        check("wr_setup_pwdata",  pwdata, 64'hA5);
        check("wr_setup_pwrite",  pwrite, 1);
        tick();
        check("wr_access_psel",    psel, 1);
        check("wr_access_penable", penable, 1);
        check("wr_access_rvalid",  rsp_valid, 0);
        tick();
        check("wr_done_psel",    psel, 0);
        check("wr_done_penable", penable, 0);
        check("wr_rsp_valid",    rsp_valid, 1);
        check("wr_rsp_write",    rsp_write, 1);
        check("wr_rsp_err",      rsp_err, 0);
        check("wr_rsp_rdata",    rsp_rdata, 0);
        check("wr_rsp_timeout",  rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        check("wr_rsp_clear", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Read with 3 wait states, slave error on the ready cycle
        pready = 1'b0;
        push(1'b0, 32'h0000_2000, 8'hFF); #1;
        check("rd_pop", fifo_rinc, 1);
        tick(); tick();
        check("rd_setup_paddr",  paddr, 64'h2000);
        check("rd_setup_pwrite", pwrite, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_access%0d", i), {psel, penable}, 2'b11);
            check($sformatf("rd_addr_stable%0d", i), paddr, 64'h2000);
            if (i == 3) begin
                pready = 1'b1; prdata = 8'h3C; pslverr = 1'b1;
            end
            tick();
        end
        check("rd_done_psel",   psel, 0);
        check("rd_rsp_valid",   rsp_valid, 1);
        check("rd_rsp_rdata",   rsp_rdata, 64'h3C);
        check("rd_rsp_err",     rsp_err, 1);
        check("rd_rsp_write",   rsp_write, 0);
        check("rd_rsp_timeout", rsp_timeout, 0);
        pready = 1'b0; prdata = 8'h77; pslverr = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout: pready held low, TIMEOUT=4
        push(1'b0, 32'h0000_3000, 8'h00);
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_access%0d", i), {psel, penable}, 2'b11);
            tick();
        end
        check("to_done_psel",    psel, 0);
        check("to_done_penable", penable, 0);
        check("to_rsp_valid",    rsp_valid, 1);
        check("to_rsp_timeout",  rsp_timeout, 1);
        check("to_rsp_err",      rsp_err, 1);
        check("to_rsp_rdata",    rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        prdata = 8'h00;

        // Backpressure with two queued writes
        pready = 1'b1;
        push(1'b1, 32'h0000_4000, 8'h11);
        push(1'b1, 32'h0000_4004, 8'h22);
        tick(); tick(); tick(); tick();
        check("bp_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_rinc%0d", i), fifo_rinc, 0);
            check($sformatf("bp_hold_rsp%0d", i), {rsp_valid, rsp_write, rsp_err, rsp_timeout, rsp_rdata}, {4'b1100, 8'h00});
            check($sformatf("bp_hold_psel%0d", i), psel, 0);
            tick();
        end
        rsp_ready = 1'b1; #1;
        check("bp_rinc_pending", fifo_rinc, 0);
        tick();
        check("bp_rsp_clear", rsp_valid, 0);
        rsp_ready = 1'b0; #1;
        check("bp_second_pop", fifo_rinc, 1);
        tick(); tick();
        check("bp_second_paddr",  paddr, 64'h4004);
        check("bp_second_pwdata", pwdata, 64'h22);
        tick(); tick();
        check("bp_second_rsp", {rsp_valid, rsp_write}, 2'b11);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during ACCESS drops the bus and discards the entry
        pready = 1'b0;
        push(1'b0, 32'h0000_5000, 8'h00);
        push(1'b1, 32'h0000_6000, 8'h66);
        tick(); tick(); tick();
        check("mr_access", {psel, penable}, 2'b11);
        prst = 1'b1; #1;
        check("mr_psel",    psel, 0);
        check("mr_penable", penable, 0);
        tick();
        prst = 1'b0; pready = 1'b1; #1;
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_pop",       fifo_rinc, 1);
        tick(); tick();
        check("mr_next_paddr",  paddr, 64'h6000);
        check("mr_next_pwrite", pwrite, 1);
        tick(); tick();
        check("mr_next_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
